// File: rtl/alu_operand_stage.sv
// Register-read / operand-select stage ahead of the ALU: 31-entry register file,
// scoreboard-based RAW/WAW stall, and a registered valid/ready bundle.
module alu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LIT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic [4:0]        in_rc,
    input  logic [LIT_W-1:0]  in_lit,
    input  logic              in_use_lit,
    input  logic              in_wr,
    input  logic [5:0]        in_fn,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [5:0]        out_fn,
    output logic [4:0]        out_rc,
    output logic              out_wr
);

    localparam int unsigned NREG  = 31;
    localparam logic [4:0]  R_ZERO = 5'd31;

    logic [DATA_W-1:0] rf_q [NREG];
    logic [NREG-1:0]   sb_q, sb_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [5:0]        out_fn_q, out_fn_d;
    logic [4:0]        out_rc_q, out_rc_d;
    logic              out_wr_q, out_wr_d;

    logic              wb_live, issue, hazard;
    logic [DATA_W-1:0] rd_a, rd_b, lit_ext;

    // Pending write that is not being retired by this cycle's writeback.
    function automatic logic pend(input logic [NREG-1:0] sb, input logic [4:0] addr,
                                  input logic wen, input logic [4:0] waddr);
        if (addr == R_ZERO) return 1'b0;
        return sb[addr] && !(wen && (waddr == addr));
    endfunction

    assign wb_live = wb_en && (wb_addr != R_ZERO);
    assign lit_ext = {{(DATA_W-LIT_W){in_lit[LIT_W-1]}}, in_lit};

    // Write-first combinational reads; R31 is hardwired zero.
    assign rd_a = (in_ra == R_ZERO) ? '0 :
                  (wb_live && (wb_addr == in_ra)) ? wb_data : rf_q[in_ra];
    assign rd_b = (in_rb == R_ZERO) ? '0 :
                  (wb_live && (wb_addr == in_rb)) ? wb_data : rf_q[in_rb];

    assign hazard = pend(sb_q, in_ra, wb_en, wb_addr)
                 || (!in_use_lit && pend(sb_q, in_rb, wb_en, wb_addr))
                 || (in_wr && pend(sb_q, in_rc, wb_en, wb_addr));
    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign issue    = in_valid && in_ready;

    always_comb begin
        sb_d        = sb_q;
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_fn_d    = out_fn_q;
        out_rc_d    = out_rc_q;
        out_wr_d    = out_wr_q;
        if (wb_live) sb_d[wb_addr] = 1'b0;
        if (issue && in_wr && (in_rc != R_ZERO)) sb_d[in_rc] = 1'b1;
        if (issue) begin
            out_valid_d = 1'b1;
            out_a_d     = rd_a;
            out_b_d     = in_use_lit ? lit_ext : rd_b;
            out_fn_d    = in_fn;
            out_rc_d    = in_rc;
            out_wr_d    = in_wr;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q        <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_fn_q    <= '0;
            out_rc_q    <= '0;
            out_wr_q    <= 1'b0;
        end else begin
            sb_q        <= sb_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_fn_q    <= out_fn_d;
            out_rc_q    <= out_rc_d;
            out_wr_q    <= out_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_fn    = out_fn_q;
    assign out_rc    = out_rc_q;
    assign out_wr    = out_wr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed plan steps plus a
// randomized phase against a per-cycle behavioural model of the stage.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_use_lit, in_wr;
    logic [4:0]  in_ra, in_rb, in_rc, wb_addr, out_rc;
    logic [15:0] in_lit;
    logic [5:0]  in_fn, out_fn;
    logic        wb_en, out_valid, out_ready, out_wr;
    logic [31:0] wb_data, out_a, out_b;

    alu_operand_stage #(.DATA_W(32), .LIT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc), .in_lit(in_lit),
        .in_use_lit(in_use_lit), .in_wr(in_wr), .in_fn(in_fn),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
        .out_fn(out_fn), .out_rc(out_rc), .out_wr(out_wr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: architectural registers, pending-write set, output bundle.
    logic [31:0] m_rf [32];
    bit          m_pend [32];
    logic        m_ov, m_wr;
    logic [31:0] m_a, m_b;
    logic [5:0]  m_fn;
    logic [4:0]  m_rc;
    logic        rdy_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] x);
        if (x == 5'd31) return 32'd0;
        if (wb_en && wb_addr == x) return wb_data;
        return m_rf[x];
    endfunction

    function automatic bit m_busy(input logic [4:0] x);
        if (x == 5'd31) return 1'b0;
        return m_pend[x] && !(wb_en && wb_addr == x);
    endfunction

    task automatic idle();
        in_valid = 0; in_ra = 0; in_rb = 0; in_rc = 0; in_lit = 0;
        in_use_lit = 0; in_wr = 0; in_fn = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    endtask

    // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
    task automatic cyc();
        bit haz, rdy, iss;
        @(negedge clk);
        haz = m_busy(in_ra) || (!in_use_lit && m_busy(in_rb)) || (in_wr && m_busy(in_rc));
        rdy = !haz && (!m_ov || out_ready);
        rdy_s = in_ready;
        if (!reset) chk("in_ready", 32'(in_ready), 32'(rdy));
        iss = in_valid && rdy;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_pend[i] = 0; end
            m_ov = 0; m_a = 0; m_b = 0; m_fn = 0; m_rc = 0; m_wr = 0;
        end else begin
            if (iss) begin
                m_a  = m_rd(in_ra);
                m_b  = in_use_lit ? {{16{in_lit[15]}}, in_lit} : m_rd(in_rb);
                m_fn = in_fn; m_rc = in_rc; m_wr = in_wr; m_ov = 1;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end
            if (wb_en && wb_addr != 5'd31) begin
                m_rf[wb_addr] = wb_data;
                m_pend[wb_addr] = 0;
            end
            if (iss && in_wr && in_rc != 5'd31) m_pend[in_rc] = 1;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_a", out_a, m_a);
        chk("out_b", out_b, m_b);
        chk("out_fn", 32'(out_fn), 32'(m_fn));
        chk("out_rc", 32'(out_rc), 32'(m_rc));
        chk("out_wr", 32'(out_wr), 32'(m_wr));
    endtask

    logic [31:0] sa, sb;
    logic [5:0]  sfn;

    initial begin
        idle(); out_ready = 1; reset = 1;
        cyc(); cyc();
        reset = 0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);

        // Reset then read.
        in_valid = 1; in_ra = 3; in_rb = 4; in_fn = 6'h20; cyc();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_a", out_a, 32'd0);
        chk("t1_b", out_b, 32'd0);
        chk("t1_fn", 32'(out_fn), 32'h20);

        // Literal sign-extension.
        idle(); wb_en = 1; wb_addr = 1; wb_data = 32'h5; cyc();
        idle(); in_valid = 1; in_ra = 1; in_lit = 16'hFFFE; in_use_lit = 1; cyc();
        chk("t2_a", out_a, 32'h5);
        chk("t2_b", out_b, 32'hFFFF_FFFE);

        // Write-first bypass, then R31 write ignored.
        idle(); in_valid = 1; in_ra = 2; wb_en = 1; wb_addr = 2; wb_data = 32'h1234; cyc();
        chk("t3_bypass", out_a, 32'h1234);
        idle(); wb_en = 1; wb_addr = 31; wb_data = 7; cyc();
        idle(); in_valid = 1; in_ra = 31; in_rb = 31; cyc();
        chk("t3_r31_a", out_a, 32'd0);
        chk("t3_r31_b", out_b, 32'd0);

        // RAW stall released by writeback of R5.
        idle(); in_valid = 1; in_rc = 5; in_wr = 1; cyc();
        idle(); in_valid = 1; in_ra = 5; cyc();
        chk("t4_stall0", 32'(rdy_s), 32'd0);
        cyc();
        chk("t4_stall1", 32'(rdy_s), 32'd0);
        wb_en = 1; wb_addr = 5; wb_data = 9; cyc();
        chk("t4_release", 32'(rdy_s), 32'd1);
        chk("t4_a", out_a, 32'd9);

        // Back-pressure holds the bundle.
        idle(); in_valid = 1; in_ra = 2; in_lit = 16'h0042; in_use_lit = 1; in_fn = 6'h11; cyc();
        sa = out_a; sb = out_b; sfn = out_fn;
        out_ready = 0; in_ra = 1; in_fn = 6'h3; in_lit = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_ready", 32'(rdy_s), 32'd0);
            chk("t5_hold_a", out_a, sa);
            chk("t5_hold_b", out_b, sb);
            chk("t5_hold_fn", 32'(out_fn), 32'(sfn));
        end
        out_ready = 1; cyc();
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_new_a", out_a, 32'h5);
        chk("t5_new_b", out_b, 32'hFFFF_8000);

        // Reset mid-operation discards bundle and scoreboard.
        idle(); in_valid = 1; in_rc = 5; in_wr = 1; cyc();
        idle(); out_ready = 0; cyc();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        reset = 1; cyc(); reset = 0; out_ready = 1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        in_valid = 1; in_ra = 5; cyc();
        chk("t6_ready", 32'(rdy_s), 32'd1);
        chk("t6_a", out_a, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            in_valid   = 1'($urandom_range(0, 3) != 0);
            in_ra      = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            in_rb      = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            in_rc      = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            in_lit     = 16'($urandom);
            in_use_lit = 1'($urandom_range(0, 1));
            in_wr      = 1'($urandom_range(0, 1));
            in_fn      = 6'($urandom);
            wb_en      = 1'($urandom_range(0, 1));
            wb_addr    = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            out_ready  = 1'($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
